// File: rtl/conv_pkg.sv
// Shared types for the convolution result collector: FSM states and the
// default-configuration FIFO entry layout.
package conv_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARM    = 2'd1,
    COLLECT = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  // Entry layout for the default configuration (NUM_OUT = 16).
  typedef struct packed {
    logic [DEF_IDX_W-1:0]  index;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a register-file head; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic                   push_ok,
  output logic                   pop_ok,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  assign empty   = (r_count == '0);
  assign full    = (r_count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = r_mem[r_rd];
  assign count   = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push_ok) r_wr <= r_wr + AW'(1);
      if (pop_ok)  r_rd <= r_rd + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) r_mem[r_wr] <= wdata;
  end

endmodule

// File: rtl/conv_result_collector.sv
// Re-aligns the systolic array's result stream with its input strobe, drops
// warm-up results and queues NUM_OUT indexed results per frame for the consumer.
module conv_result_collector
  import conv_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = 12,
  parameter int WARMUP  = 2,
  parameter int DEPTH   = 8,
  parameter int NUM_OUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          y_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_OUT)-1:0] out_index,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output state_e                     dbg_state
);

  localparam int IDX_W = $clog2(NUM_OUT);
  localparam int WC_W  = $clog2(WARMUP + 2);
  localparam int OC_W  = $clog2(NUM_OUT + 1);
  localparam int EW    = IDX_W + DATA_W;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [LATENCY-1:0] r_dly;
  logic [WC_W-1:0]   r_warm_cnt;
  logic [WC_W-1:0]   w_warm_nxt;
  logic [OC_W-1:0]   r_out_cnt;
  logic [OC_W-1:0]   w_out_nxt;
  logic              r_overflow;
  logic              w_aligned;
  logic              w_clear;
  logic              w_warm_inc;
  logic              w_push_req;
  logic              w_done;
  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [EW-1:0]     w_push_word;
  logic [EW-1:0]     w_head;

  // The strobe delay line runs in every state so alignment never depends on the FSM.
  assign w_aligned = r_dly[LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dly <= '0;
    else     r_dly <= LATENCY'({r_dly, in_valid});
  end

  assign w_warm_nxt  = r_warm_cnt + WC_W'(1);
  assign w_out_nxt   = r_out_cnt + OC_W'(1);
  assign w_push_word = {r_out_cnt[IDX_W-1:0], y_in};

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_warm_inc  = 1'b0;
    w_push_req  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = (WARMUP == 0) ? COLLECT : WARM;
        end
      end
      WARM: begin
        if (w_aligned) begin
          w_warm_inc = 1'b1;
          if (w_warm_nxt == WC_W'(WARMUP)) w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (w_aligned) begin
          w_push_req = 1'b1;
          if (w_out_nxt == OC_W'(NUM_OUT)) w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (w_empty) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_warm_cnt <= '0;
      r_out_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_warm_cnt <= '0;
        r_out_cnt  <= '0;
        r_overflow <= 1'b0;
      end
      if (w_warm_inc) r_warm_cnt <= w_warm_nxt;
      // The index advances even when the word is dropped, so gaps stay visible downstream.
      if (w_push_req) begin
        r_out_cnt <= w_out_nxt;
        if (!w_push_ok) r_overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push_req),
    .pop     (out_ready),
    .wdata   (w_push_word),
    .rdata   (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .push_ok (w_push_ok),
    .pop_ok  (w_pop_ok),
    .count   (fifo_count)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_head[DATA_W-1:0];
  assign out_index = w_empty ? '0 : w_head[EW-1:DATA_W];
  assign busy      = (r_state != IDLE);
  assign done      = w_done;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_conv_result_collector.sv
// Bench for conv_result_collector: instance A (WARMUP=2, NUM_OUT=4) for frame
// and alignment behaviour, instance B (WARMUP=0, NUM_OUT=16) for backpressure.
module tb_conv_result_collector;
  import conv_pkg::*;

  localparam int LAT = 12;

  typedef struct {
    int          pulses;
    int          gap;
    bit          rand_ready;
    logic [31:0] base;
    int          exp_out;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        a_start, a_in_valid, a_out_ready;
  logic [31:0] a_y_in;
  logic        a_out_valid, a_busy, a_done, a_overflow;
  logic [31:0] a_out_data;
  logic [1:0]  a_out_index;
  logic [3:0]  a_fifo_count;
  state_e      a_dbg_state;

  logic        b_start, b_in_valid, b_out_ready;
  logic [31:0] b_y_in;
  logic        b_out_valid, b_busy, b_done, b_overflow;
  logic [31:0] b_out_data;
  logic [3:0]  b_out_index;
  logic [3:0]  b_fifo_count;
  state_e      b_dbg_state;

  logic [31:0] ysa[int];
  logic [31:0] ysb[int];
  logic [35:0] exp_a_q[$];
  logic [35:0] exp_b_q[$];
  logic [35:0] e_a, e_b;
  int a_done_cnt = 0, b_done_cnt = 0, a_done_cyc = 0, b_done_cyc = 0;
  int a_last_pop = 0, b_last_pop = 0, a_pop_cnt = 0, b_pop_cnt = 0;
  bit a_rdy_rand = 1'b0;

  conv_result_collector #(.DATA_W(32), .LATENCY(LAT), .WARMUP(2), .DEPTH(8), .NUM_OUT(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .y_in(a_y_in),
    .out_ready(a_out_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_index(a_out_index), .fifo_count(a_fifo_count), .busy(a_busy), .done(a_done),
    .overflow(a_overflow), .dbg_state(a_dbg_state)
  );

  conv_result_collector #(.DATA_W(32), .LATENCY(LAT), .WARMUP(0), .DEPTH(8), .NUM_OUT(16)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .y_in(b_y_in),
    .out_ready(b_out_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_index(b_out_index), .fifo_count(b_fifo_count), .busy(b_busy), .done(b_done),
    .overflow(b_overflow), .dbg_state(b_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    a_y_in = ysa.exists(cyc) ? ysa[cyc] : 32'h5555;
    b_y_in = ysb.exists(cyc) ? ysb[cyc] : 32'h5555;
    if (a_rdy_rand) a_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_a(input logic [31:0] val);
    a_in_valid = 1'b1;
    ysa[cyc + LAT] = val;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic pulse_b(input logic [31:0] val);
    b_in_valid = 1'b1;
    ysb[cyc + LAT] = val;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_done_a(input string tag);
    int n0;
    int i;
    n0 = a_done_cnt;
    i = 0;
    while (a_done_cnt == n0 && i < 400) begin tick(); i++; end
    check({tag, "_done"}, 64'(a_done_cnt - n0), 64'd1);
    check({tag, "_done_lat"}, 64'(a_done_cyc - a_last_pop), 64'd1);
  endtask

  task automatic wait_done_b(input string tag);
    int n0;
    int i;
    n0 = b_done_cnt;
    i = 0;
    while (b_done_cnt == n0 && i < 400) begin tick(); i++; end
    check({tag, "_done"}, 64'(b_done_cnt - n0), 64'd1);
    check({tag, "_done_lat"}, 64'(b_done_cyc - b_last_pop), 64'd1);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_a_valid"}, 64'(a_out_valid), 64'd0);
    check({tag, "_a_data"}, 64'(a_out_data), 64'd0);
    check({tag, "_a_index"}, 64'(a_out_index), 64'd0);
    check({tag, "_a_count"}, 64'(a_fifo_count), 64'd0);
    check({tag, "_a_busy"}, 64'(a_busy), 64'd0);
    check({tag, "_a_done"}, 64'(a_done), 64'd0);
    check({tag, "_a_ovf"}, 64'(a_overflow), 64'd0);
  endtask

  task automatic check_zero_b(input string tag);
    check({tag, "_b_valid"}, 64'(b_out_valid), 64'd0);
    check({tag, "_b_data"}, 64'(b_out_data), 64'd0);
    check({tag, "_b_count"}, 64'(b_fifo_count), 64'd0);
    check({tag, "_b_busy"}, 64'(b_busy), 64'd0);
    check({tag, "_b_ovf"}, 64'(b_overflow), 64'd0);
  endtask

  // scoreboard: pop and compare on every accepted output beat
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      a_pop_cnt++;
      a_last_pop = cyc;
      if (exp_a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_pop_unexpected actual=%0h required=none", {a_out_index, a_out_data});
      end else begin
        e_a = exp_a_q.pop_front();
        check("a_pop", 64'({a_out_index, a_out_data}), 64'(e_a));
      end
    end
    if (!rst && b_out_valid && b_out_ready) begin
      b_pop_cnt++;
      b_last_pop = cyc;
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_pop_unexpected actual=%0h required=none", {b_out_index, b_out_data});
      end else begin
        e_b = exp_b_q.pop_front();
        check("b_pop", 64'({b_out_index, b_out_data}), 64'(e_b));
      end
    end
    if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
    if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
  end

  initial begin
    frame_t frames[4];
    int p0, c0, c8, cl, i, na, nb;
    frames[0] = '{pulses: 6, gap: 0, rand_ready: 1'b0, base: 32'd100, exp_out: 4};
    frames[1] = '{pulses: 7, gap: 2, rand_ready: 1'b1, base: 32'd200, exp_out: 4};
    frames[2] = '{pulses: 8, gap: 1, rand_ready: 1'b1, base: 32'd300, exp_out: 4};
    frames[3] = '{pulses: 6, gap: 3, rand_ready: 1'b0, base: 32'd400, exp_out: 4};

    rst = 1'b1;
    a_start = 0; a_in_valid = 0; a_out_ready = 1; a_y_in = 32'h5555;
    b_start = 0; b_in_valid = 0; b_out_ready = 0; b_y_in = 32'h5555;
    repeat (3) tick();
    check_zero_a("reset");
    check_zero_b("reset");
    rst = 1'b0;
    tick();

    // table-driven frames on A
    for (int f = 0; f < 4; f++) begin
      a_rdy_rand  = frames[f].rand_ready;
      a_out_ready = 1'b1;
      p0 = a_pop_cnt;
      a_start = 1'b1; tick(); a_start = 1'b0;
      check("frame_state_warm", 64'(a_dbg_state), 64'(WARM));
      check("frame_busy", 64'(a_busy), 64'd1);
      for (int k = 0; k < frames[f].pulses; k++) begin
        if (k >= 2 && k < 6) exp_a_q.push_back({2'b00, 2'(k - 2), 32'(frames[f].base + 32'(k))});
        pulse_a(frames[f].base + 32'(k));
        repeat (frames[f].gap) tick();
      end
      wait_done_a("frame");
      check("frame_pops", 64'(a_pop_cnt - p0), 64'(frames[f].exp_out));
      check("frame_q_empty", 64'(exp_a_q.size()), 64'd0);
      check("frame_idle", 64'(a_busy), 64'd0);
      a_rdy_rand = 1'b0;
      a_out_ready = 1'b1;
      repeat (LAT + 2) tick();
    end

    // alignment: a single strobe is counted exactly once as a warm-up discard
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (3) tick();
    c0 = cyc;
    pulse_a(32'hAAAA);
    wait_until(c0 + LAT);
    check("align_warm_at", 64'(a_dbg_state), 64'(WARM));
    repeat (12) tick();
    check("align_still_warm", 64'(a_dbg_state), 64'(WARM));
    c0 = cyc;
    pulse_a(32'h1234);
    wait_until(c0 + LAT + 1);
    check("align_collect", 64'(a_dbg_state), 64'(COLLECT));
    for (int k = 0; k < 4; k++) begin
      exp_a_q.push_back({2'b00, 2'(k), 32'h700 + 32'(k)});
      pulse_a(32'h700 + 32'(k));
    end
    wait_done_a("align");
    repeat (LAT + 2) tick();

    // B frame 1: full FIFO with simultaneous push and pop
    b_out_ready = 1'b0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    check("pp_state", 64'(b_dbg_state), 64'(COLLECT));
    for (int k = 0; k < 8; k++) begin
      exp_b_q.push_back({4'(k), 32'h2000 + 32'(k)});
      pulse_b(32'h2000 + 32'(k));
    end
    cl = cyc - 1;
    wait_until(cl + LAT + 1);
    check("pp_full_count", 64'(b_fifo_count), 64'd8);
    check("pp_full_ovf", 64'(b_overflow), 64'd0);
    c8 = cyc;
    exp_b_q.push_back({4'd8, 32'h2008});
    pulse_b(32'h2008);
    wait_until(c8 + LAT);
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
    check("pp_count_held", 64'(b_fifo_count), 64'd8);
    check("pp_no_ovf", 64'(b_overflow), 64'd0);
    b_out_ready = 1'b1;
    for (int k = 9; k < 16; k++) begin
      exp_b_q.push_back({4'(k), 32'h2000 + 32'(k)});
      pulse_b(32'h2000 + 32'(k));
    end
    wait_done_b("pp");
    check("pp_ovf_end", 64'(b_overflow), 64'd0);
    repeat (LAT + 2) tick();

    // B frame 2: backpressure and overflow, then start during FLUSH
    b_out_ready = 1'b0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) exp_b_q.push_back({4'(k), 32'h3000 + 32'(k)});
      pulse_b(32'h3000 + 32'(k));
    end
    wait_until(c0 + LAT);
    check("bp_first_valid0", 64'(b_out_valid), 64'd0);
    tick();
    check("bp_first_valid1", 64'(b_out_valid), 64'd1);
    check("bp_first_count", 64'(b_fifo_count), 64'd1);
    wait_until(c0 + LAT + 10);
    check("bp_count8", 64'(b_fifo_count), 64'd8);
    check("bp_ovf", 64'(b_overflow), 64'd1);
    repeat (3) tick();
    check("bp_stall_data", 64'(b_out_data), 64'h3000);
    check("bp_stall_index", 64'(b_out_index), 64'd0);
    b_out_ready = 1'b1;
    i = 0;
    while (b_fifo_count != 0 && i < 40) begin tick(); i++; end
    check("bp_drained", 64'(b_fifo_count), 64'd0);
    check("bp_q_empty", 64'(exp_b_q.size()), 64'd0);
    b_out_ready = 1'b0;
    check("bp_collect", 64'(b_dbg_state), 64'(COLLECT));
    for (int k = 10; k < 16; k++) begin
      exp_b_q.push_back({4'(k), 32'h3000 + 32'(k)});
      pulse_b(32'h3000 + 32'(k));
    end
    cl = cyc - 1;
    wait_until(cl + LAT + 1);
    check("bp_flush", 64'(b_dbg_state), 64'(FLUSH));
    check("bp_flush_count", 64'(b_fifo_count), 64'd6);
    b_start = 1'b1; tick(); b_start = 1'b0;
    check("fl_start_state", 64'(b_dbg_state), 64'(FLUSH));
    check("fl_start_ovf", 64'(b_overflow), 64'd1);
    check("fl_start_count", 64'(b_fifo_count), 64'd6);
    b_out_ready = 1'b1;
    wait_done_b("bp");
    check("bp_ovf_sticky", 64'(b_overflow), 64'd1);
    check("bp_q_empty2", 64'(exp_b_q.size()), 64'd0);
    repeat (LAT + 2) tick();

    // B frame 3 and A frame, both aborted by reset mid-COLLECT
    b_out_ready = 1'b0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    check("b3_ovf_cleared", 64'(b_overflow), 64'd0);
    for (int k = 0; k < 3; k++) pulse_b(32'h4000 + 32'(k));
    a_out_ready = 1'b0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int k = 0; k < 5; k++) pulse_a(32'h5000 + 32'(k));
    repeat (LAT + 2) tick();
    check("abort_a_state", 64'(a_dbg_state), 64'(COLLECT));
    check("abort_a_count", 64'(a_fifo_count), 64'd3);
    check("abort_b_count", 64'(b_fifo_count), 64'd3);
    na = a_done_cnt;
    nb = b_done_cnt;
    rst = 1'b1;
    #2;
    check_zero_a("abort");
    check_zero_b("abort");
    exp_a_q.delete();
    exp_b_q.delete();
    tick(); tick();
    rst = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    repeat (20) tick();
    check("abort_no_done_a", 64'(a_done_cnt - na), 64'd0);
    check("abort_no_done_b", 64'(b_done_cnt - nb), 64'd0);
    check("abort_a_idle", 64'(a_dbg_state), 64'(IDLE));
    check("abort_b_valid", 64'(b_out_valid), 64'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
